// File: rtl/adc_trigger_gen.sv
// adc_trigger_gen: ADC conversion trigger source with continuous, burst and
// externally phase-aligned operation. One registered trigger pulse per period,
// a one-cycle done pulse after a burst, and a saturating trigger counter.
module adc_trigger_gen #(
    parameter int CNT_WIDTH   = 32,
    parameter int BURST_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [CNT_WIDTH-1:0]   divider,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   start,
    input  logic                   ext_sync,
    output logic                   trigger,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] trig_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]             MODE_CONT  = 2'd0;
    localparam logic [1:0]             MODE_BURST = 2'd1;
    localparam logic [1:0]             MODE_EXT   = 2'd2;
    localparam logic [CNT_WIDTH-1:0]   ONE_C      = 1;
    localparam logic [BURST_WIDTH-1:0] ONE_B      = 1;
    localparam logic [BURST_WIDTH-1:0] COUNT_MAX  = '1;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   div_q;
    logic [BURST_WIDTH-1:0] len_q;
    logic [1:0]             mode_q;      // mode frozen for the whole run
    logic [2:0]             sync_pipe;   // [0],[1] synchroniser, [2] edge-detect history

    logic start_ok;    // conditions to leave IDLE are met this cycle
    logic ext_rise;    // rising edge on the synchronised ext_sync
    logic nat_wrap;    // counter reached the end of its period
    logic wrap;        // natural or forced period boundary
    logic last_trig;   // the trigger about to fire completes the burst
    logic enter;       // leaving IDLE: latch configuration, clear counters
    logic fire;        // issue a trigger on this edge
    logic done_d;

    assign start_ok  = enable && (divider != '0) &&
                       ((mode == MODE_CONT) || (mode == MODE_EXT) ||
                        ((mode == MODE_BURST) && start));
    assign ext_rise  = sync_pipe[1] & ~sync_pipe[2];
    assign nat_wrap  = (cnt_q == div_q - ONE_C);
    assign wrap      = nat_wrap || ((mode_q == MODE_EXT) && ext_rise);
    // Bursts never exceed COUNT_MAX triggers, so the non-saturated increment
    // is exact whenever this comparison matters.
    assign last_trig = ((trig_count + ONE_B) == len_q);
    assign busy      = (state_q == ST_RUN);

    // Two-flop synchroniser for ext_sync plus one delayed copy for edge detect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], ext_sync};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; enable low always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        fire    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    enter = 1'b1;
                    // An empty burst completes immediately with no trigger.
                    if ((mode == MODE_BURST) && (burst_len == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    fire = 1'b1;
                    if (mode_q == MODE_BURST) begin
                        if (last_trig) begin
                            state_d = ST_DONE;
                        end
                    end else if (divider == '0) begin
                        // Period reload of zero stops the run; this trigger still goes out.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = enable;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Period counter, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            div_q      <= '0;
            len_q      <= '0;
            mode_q     <= MODE_CONT;
            trig_count <= '0;
            trigger    <= 1'b0;
            done       <= 1'b0;
        end else begin
            trigger <= fire;
            done    <= done_d;
            if (enter) begin
                div_q      <= divider;
                len_q      <= burst_len;
                mode_q     <= mode;
                cnt_q      <= '0;
                trig_count <= '0;
            end else if ((state_q == ST_RUN) && enable) begin
                if (fire) begin
                    cnt_q <= '0;
                    if (trig_count != COUNT_MAX) begin
                        trig_count <= trig_count + ONE_B;
                    end
                    // Continuous/ext runs pick up a new period only at a boundary.
                    if (mode_q != MODE_BURST) begin
                        div_q <= divider;
                    end
                end else begin
                    cnt_q <= cnt_q + ONE_C;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_trigger_gen.sv
// Bench for adc_trigger_gen: vector table, directed scenarios and a random
// run, all compared against a deadline-based reference model.
module tb_adc_trigger_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] divider;
    logic [15:0] burst_len;
    logic        start;
    logic        ext_sync;
    logic        trigger;
    logic        busy;
    logic        done;
    logic [15:0] trig_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_trigger_gen #(.CNT_WIDTH(32), .BURST_WIDTH(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mode      (mode),
        .divider   (divider),
        .burst_len (burst_len),
        .start     (start),
        .ext_sync  (ext_sync),
        .trigger   (trigger),
        .busy      (busy),
        .done      (done),
        .trig_count(trig_count)
    );

    // Reference model: RUN schedules the next trigger as an absolute edge number.
    int          edge_n = 0;
    int          m_state;          // 0 idle, 1 run, 2 done
    longint      m_next;
    int unsigned m_div;
    int          m_len;
    int          m_mode;
    int          m_cnt;
    bit          hist[$];          // ext_sync value seen at each edge
    bit          e_trig, e_busy, e_done;
    int          trig_q[$];
    int          done_q[$];

    function automatic void chk(string nm, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
        end
    endfunction

    function automatic int qat(int k);
        return (k < trig_q.size()) ? trig_q[k] : -1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        hist.delete();
        e_trig  = 0;
        e_busy  = 0;
        e_done  = 0;
    endtask

    task automatic model_edge();
        bit rise;
        bit nat;
        bit frc;
        int n;
        edge_n++;
        hist.push_back(ext_sync);
        if (hist.size() > 8) void'(hist.pop_front());
        n = hist.size();
        // A high first seen at edge k is acted on at edge k+2.
        rise = (n >= 3) && hist[n-3] && !((n >= 4) && hist[n-4]);
        e_trig = 0;
        e_done = 0;
        if (!enable) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: begin
                    if (divider != 0 && (mode == 0 || mode == 2 || (mode == 1 && start))) begin
                        m_div  = divider;
                        m_len  = burst_len;
                        m_mode = mode;
                        m_cnt  = 0;
                        if (mode == 1 && burst_len == 0) m_state = 2;
                        else begin
                            m_state = 1;
                            m_next  = edge_n + longint'(divider);
                        end
                    end
                end
                1: begin
                    nat = (edge_n == m_next);
                    frc = (m_mode == 2) && rise;
                    if (nat || frc) begin
                        e_trig = 1;
                        if (m_cnt < 65535) m_cnt++;
                        if (m_mode == 1) begin
                            if (m_cnt == m_len) m_state = 2;
                            else m_next = edge_n + longint'(m_div);
                        end else begin
                            m_div = divider;
                            if (divider == 0) m_state = 0;
                            else m_next = edge_n + longint'(divider);
                        end
                    end
                end
                default: begin
                    e_done  = 1;
                    m_state = 0;
                end
            endcase
        end
        e_busy = (m_state == 1);
    endtask

    // Called at a negedge: drive, take one posedge, compare at the next negedge.
    task automatic step(input bit en, input bit [1:0] md, input int unsigned dv,
                        input int unsigned bl, input bit st, input bit ex);
        enable    = en;
        mode      = md;
        divider   = dv;
        burst_len = bl[15:0];
        start     = st;
        ext_sync  = ex;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", {trigger, busy, done, trig_count},
            {e_trig, e_busy, e_done, m_cnt[15:0]});
        if (trigger && done) chk("trig_done_excl", 1, 0);
        if (trigger) trig_q.push_back(edge_n);
        if (done) done_q.push_back(edge_n);
    endtask

    typedef struct {
        bit          en;
        bit [1:0]    md;
        int unsigned dv;
        int unsigned bl;
        bit          st;
        bit          trg;
        bit          bsy;
        bit          dn;
        int          cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int e0;
        // divider=1 burst of 4, then the zero-divider, reserved-mode and empty-burst cases
        tbl[0]  = '{1'b1, 2'd1, 1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 2'd1, 1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b1, 2'd1, 1, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b1, 2'd1, 1, 4, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tbl[4]  = '{1'b1, 2'd1, 1, 4, 1'b0, 1'b1, 1'b1, 1'b0, 3};
        tbl[5]  = '{1'b1, 2'd1, 1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        tbl[6]  = '{1'b1, 2'd1, 1, 4, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        tbl[7]  = '{1'b1, 2'd1, 1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        tbl[8]  = '{1'b1, 2'd1, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        tbl[9]  = '{1'b1, 2'd3, 5, 4, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        tbl[10] = '{1'b1, 2'd1, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b1, 2'd1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[12] = '{1'b1, 2'd1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        resetn = 0; enable = 0; mode = 0; divider = 0;
        burst_len = 0; start = 0; ext_sync = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", {trigger, busy, done, trig_count}, 0);
        resetn = 1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].md, tbl[i].dv, tbl[i].bl, tbl[i].st, 0);
            chk($sformatf("vec%0d", i), {trigger, busy, done, trig_count},
                {tbl[i].trg, tbl[i].bsy, tbl[i].dn, tbl[i].cnt[15:0]});
        end

        // Continuous, period 10, switching to 4 mid-period.
        trig_q.delete(); done_q.delete();
        step(1, 0, 10, 0, 0, 0);
        e0 = edge_n;
        for (int i = 1; i <= 53; i++) step(1, 0, (i < 35) ? 10 : 4, 0, 0, 0);
        chk("cont_ntrig", trig_q.size(), 7);
        for (int k = 0; k < 7; k++)
            chk("cont_trig_edge", qat(k) - e0, (k < 4) ? 10 * (k + 1) : 40 + 4 * (k - 3));
        chk("cont_count", trig_count, 7);
        step(0, 0, 4, 0, 0, 0);
        chk("cont_stop_busy", busy, 0);

        // Burst of 3 at period 5, with a second start ignored mid-run.
        trig_q.delete(); done_q.delete();
        step(1, 1, 5, 3, 1, 0);
        e0 = edge_n;
        for (int i = 1; i <= 20; i++) step(1, 1, 5, 3, (i == 7), 0);
        chk("burst_ntrig", trig_q.size(), 3);
        for (int k = 0; k < 3; k++) chk("burst_trig_edge", qat(k) - e0, 5 * (k + 1));
        chk("burst_ndone", done_q.size(), 1);
        chk("burst_done_edge", (done_q.size() > 0) ? done_q[0] - e0 : -1, 16);
        chk("burst_busy_after", busy, 0);
        chk("burst_count", trig_count, 3);

        // Enable dropped mid-burst: no done pulse, count held.
        trig_q.delete(); done_q.delete();
        step(1, 1, 5, 3, 1, 0);
        for (int i = 1; i <= 6; i++) step(1, 1, 5, 3, 0, 0);
        step(0, 1, 5, 3, 0, 0);
        chk("abort_outputs", {trigger, busy, done}, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 5, 3, 0, 0);
        chk("abort_ndone", done_q.size(), 0);
        chk("abort_count", trig_count, 1);

        // Ext sync: mid-period pulse, then one aligned with a natural wrap.
        trig_q.delete(); done_q.delete();
        step(1, 2, 100, 0, 0, 0);
        e0 = edge_n;
        for (int i = 1; i <= 240; i++) step(1, 2, 100, 0, 0, (i == 30 || i == 130));
        chk("ext_ntrig", trig_q.size(), 3);
        chk("ext_trig0", qat(0) - e0, 32);
        chk("ext_trig1", qat(1) - e0, 132);
        chk("ext_trig2", qat(2) - e0, 232);
        step(0, 2, 100, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle while a trigger is high.
        step(1, 0, 10, 0, 0, 0);
        for (int i = 1; i <= 10; i++) step(1, 0, 10, 0, 0, 0);
        chk("pre_rst_trig", trigger, 1);
        #2 resetn = 0;
        #1 chk("async_rst", {trigger, busy, done, trig_count}, 0);
        model_reset();
        @(negedge clk);
        resetn = 1;
        step(1, 1, 3, 2, 0, 0);

        // Random segments with fixed configuration per segment.
        for (int s = 0; s < 150; s++) begin
            bit [1:0]    md;
            int unsigned dv;
            int unsigned bl;
            md = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            dv = $urandom_range(0, 6);
            bl = $urandom_range(0, 5);
            for (int c = 0; c < 20; c++)
                step($urandom_range(0, 19) != 0, md, dv, bl,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
